// File: rtl/turn_pkg.sv
// Shared types and helpers for the turn/move checker: FSM states, reject causes
// and width derivation.
package turn_pkg;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_FULL   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_FULL     = 3'd1,
    CAUSE_RANGE    = 3'd2,
    CAUSE_TURN     = 3'd3,
    CAUSE_OCCUPIED = 3'd4
  } cause_e;

  typedef struct packed {
    logic full;
    logic out_of_range;
    logic turn;
    logic occupied;
  } err_flags_t;

  // $clog2 that never yields a zero-width vector
  function automatic int safe_clog2(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic err_flags_t cause_flags(input cause_e cause);
    err_flags_t f;
    f = '0;
    case (cause)
      CAUSE_FULL:     f.full         = 1'b1;
      CAUSE_RANGE:    f.out_of_range = 1'b1;
      CAUSE_TURN:     f.turn         = 1'b1;
      CAUSE_OCCUPIED: f.occupied     = 1'b1;
      default:        f              = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/turn_move_checker_if.sv
// Move-strobe and status bundle between the move decoder (master) and the
// turn/move checker (slave).
interface turn_move_checker_if
  import turn_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_CELLS   = 9
);
  localparam int PW = safe_clog2(NUM_PLAYERS);
  localparam int CW = safe_clog2(NUM_CELLS);
  localparam int MW = safe_clog2(NUM_CELLS + 1);

  logic                 new_game;
  logic                 move_valid;
  logic [PW-1:0]        move_player;
  logic [CW-1:0]        move_cell;
  logic                 move_accept;
  logic                 move_reject;
  logic                 err_turn;
  logic                 err_occupied;
  logic                 err_range;
  logic                 err_full;
  logic                 locked;
  logic [PW-1:0]        next_player;
  logic [NUM_CELLS-1:0] marked;
  logic [MW-1:0]        move_count;
  logic                 board_full;

  modport master (
    output new_game, move_valid, move_player, move_cell,
    input  move_accept, move_reject, err_turn, err_occupied, err_range, err_full,
           locked, next_player, marked, move_count, board_full
  );

  modport slave (
    input  new_game, move_valid, move_player, move_cell,
    output move_accept, move_reject, err_turn, err_occupied, err_range, err_full,
           locked, next_player, marked, move_count, board_full
  );

endinterface

// File: rtl/turn_rotator.sv
// Modulo-NUM_PLAYERS turn counter: load restarts at FIRST_PLAYER, advance steps
// to the next player with wrap to 0.
module turn_rotator #(
  parameter int NUM_PLAYERS  = 2,
  parameter int FIRST_PLAYER = 0,
  parameter int PW           = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          advance_i,
  output logic [PW-1:0] next_player_o
);

  localparam logic [PW-1:0] FIRST = PW'(FIRST_PLAYER);
  localparam logic [PW-1:0] LAST  = PW'(NUM_PLAYERS - 1);

  logic [PW-1:0] player_q, player_d;

  // next player selection; load has priority over advance
  always_comb begin
    player_d = player_q;
    if (load_i) begin
      player_d = FIRST;
    end else if (advance_i) begin
      player_d = (player_q == LAST) ? '0 : player_q + PW'(1);
    end else begin
      player_d = player_q;
    end
  end

  // player register
  always_ff @(posedge clk) begin
    if (reset) begin
      player_q <= FIRST;
    end else begin
      player_q <= player_d;
    end
  end

  assign next_player_o = player_q;

endmodule

// File: rtl/turn_move_checker.sv
// Validates each move strobe for turn order, cell range and occupancy, and keeps
// the board bitmap, move count, error flags and PLAY/FULL/LOCKED state.
module turn_move_checker
  import turn_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_CELLS     = 9,
  parameter int FIRST_PLAYER  = 0,
  parameter int LOCK_ON_ERROR = 1
) (
  input logic                clk,
  input logic                reset,
  turn_move_checker_if.slave bus
);

  localparam int PW = safe_clog2(NUM_PLAYERS);
  localparam int MW = safe_clog2(NUM_CELLS + 1);

  localparam logic [MW-1:0] FULL_COUNT    = MW'(NUM_CELLS);
  localparam logic [31:0]   NUM_CELLS_W   = 32'(NUM_CELLS);
  localparam logic [31:0]   NUM_PLAYERS_W = 32'(NUM_PLAYERS);

  state_e               state_q, state_d;
  logic [NUM_CELLS-1:0] marked_q, marked_d;
  logic [MW-1:0]        count_q, count_d;
  err_flags_t           err_q, err_d;
  logic                 accept_q, accept_d;
  logic                 reject_q, reject_d;
  logic                 rot_load;
  logic                 rot_advance;
  logic [PW-1:0]        next_player;
  cause_e               cause;

  turn_rotator #(
    .NUM_PLAYERS  (NUM_PLAYERS),
    .FIRST_PLAYER (FIRST_PLAYER),
    .PW           (PW)
  ) u_rotator (
    .clk           (clk),
    .reset         (reset),
    .load_i        (rot_load),
    .advance_i     (rot_advance),
    .next_player_o (next_player)
  );

  // reject cause, first match wins; the occupancy lookup is only reached for in-range cells
  always_comb begin
    cause = CAUSE_NONE;
    if (state_q == ST_FULL) begin
      cause = CAUSE_FULL;
    end else if (32'(bus.move_cell) >= NUM_CELLS_W) begin
      cause = CAUSE_RANGE;
    end else if ((32'(bus.move_player) >= NUM_PLAYERS_W) || (bus.move_player != next_player)) begin
      cause = CAUSE_TURN;
    end else if (marked_q[bus.move_cell]) begin
      cause = CAUSE_OCCUPIED;
    end else begin
      cause = CAUSE_NONE;
    end
  end

  // next state, board update and result pulses; new_game overrides any move
  always_comb begin
    state_d     = state_q;
    marked_d    = marked_q;
    count_d     = count_q;
    err_d       = err_q;
    accept_d    = 1'b0;
    reject_d    = 1'b0;
    rot_load    = 1'b0;
    rot_advance = 1'b0;
    if (bus.new_game) begin
      state_d  = ST_PLAY;
      marked_d = '0;
      count_d  = '0;
      err_d    = '0;
      rot_load = 1'b1;
    end else if (bus.move_valid && (state_q != ST_LOCKED)) begin
      if (cause == CAUSE_NONE) begin
        accept_d               = 1'b1;
        marked_d[bus.move_cell] = 1'b1;
        count_d                = count_q + MW'(1);
        err_d                  = '0;
        rot_advance            = 1'b1;
        if ((count_q + MW'(1)) == FULL_COUNT) begin
          state_d = ST_FULL;
        end else begin
          state_d = state_q;
        end
      end else begin
        reject_d = 1'b1;
        err_d    = cause_flags(cause);
        if (LOCK_ON_ERROR != 0) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = state_q;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_PLAY;
      marked_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      marked_q <= marked_d;
      count_q  <= count_d;
      err_q    <= err_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
    end
  end

  assign bus.move_accept  = accept_q;
  assign bus.move_reject  = reject_q;
  assign bus.err_full     = err_q.full;
  assign bus.err_range    = err_q.out_of_range;
  assign bus.err_turn     = err_q.turn;
  assign bus.err_occupied = err_q.occupied;
  assign bus.locked       = (state_q == ST_LOCKED);
  assign bus.next_player  = next_player;
  assign bus.marked       = marked_q;
  assign bus.move_count   = count_q;
  assign bus.board_full   = (count_q == FULL_COUNT);

endmodule

// File: tb/tb_turn_move_checker.sv
// Bench for turn_move_checker: three configurations checked against a rule-level
// reference model, with a directed vector table, hand sequences and random moves.
module tb_turn_move_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  turn_move_checker_if #(.NUM_PLAYERS(2), .NUM_CELLS(9))  if0 ();
  turn_move_checker_if #(.NUM_PLAYERS(2), .NUM_CELLS(9))  if1 ();
  turn_move_checker_if #(.NUM_PLAYERS(3), .NUM_CELLS(12)) if2 ();

  turn_move_checker #(.NUM_PLAYERS(2), .NUM_CELLS(9), .FIRST_PLAYER(0), .LOCK_ON_ERROR(1))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  turn_move_checker #(.NUM_PLAYERS(2), .NUM_CELLS(9), .FIRST_PLAYER(0), .LOCK_ON_ERROR(0))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  turn_move_checker #(.NUM_PLAYERS(3), .NUM_CELLS(12), .FIRST_PLAYER(0), .LOCK_ON_ERROR(0))
    u2 (.clk(clk), .reset(reset), .bus(if2));

  int np_c[3]   = '{2, 2, 3};
  int nc_c[3]   = '{9, 9, 12};
  int lk_c[3]   = '{1, 0, 0};
  int maxp_c[3] = '{1, 1, 3};

  // err nibble order: {full, range, turn, occupied}; st: 0 play, 1 full, 2 locked
  typedef struct packed {
    logic [255:0] marked;
    logic [15:0]  count;
    logic [7:0]   nxt;
    logic [3:0]   err;
    logic [1:0]   st;
    logic         acc;
    logic         rej;
  } model_t;

  typedef struct {
    int       which;
    bit       ng;
    bit       mv;
    int       p;
    int       c;
    bit       acc;
    bit       rej;
    bit [3:0] err;
    int       nxt;
    int       cnt;
  } vec_t;

  model_t mdl[3];
  vec_t   tbl[$];
  int     errors = 0;
  int     checks = 0;

  function automatic model_t model_step(model_t m, int np, int nc, int lock,
                                        bit ng, bit mv, int p, int c);
    model_t   r;
    bit [3:0] e;
    r     = m;
    r.acc = 1'b0;
    r.rej = 1'b0;
    e     = 4'h0;
    if (ng) begin
      r = '0;
    end else if (mv && m.st != 2'd2) begin
      if (m.st == 2'd1)                       e = 4'b1000;
      else if (c >= nc)                       e = 4'b0100;
      else if (p >= np || p != int'(m.nxt))   e = 4'b0010;
      else if (m.marked[c[7:0]])              e = 4'b0001;
      if (e == 4'h0) begin
        r.acc            = 1'b1;
        r.marked[c[7:0]] = 1'b1;
        r.count          = 16'(int'(m.count) + 1);
        r.nxt            = 8'((int'(m.nxt) + 1) % np);
        r.err            = 4'h0;
        if (int'(r.count) == nc) r.st = 2'd1;
      end else begin
        r.rej = 1'b1;
        r.err = e;
        if (lock != 0) r.st = 2'd2;
      end
    end
    return r;
  endfunction

  // layout: acc, rej, err[3:0], locked, next[7:0], count[15:0], full, marked[255:0]
  function automatic logic [287:0] exp_vec(int k);
    model_t m;
    m = mdl[k];
    return {m.acc, m.rej, m.err, (m.st == 2'd2), m.nxt, m.count,
            (int'(m.count) == nc_c[k]), m.marked};
  endfunction

  function automatic logic [287:0] act_vec(int k);
    case (k)
      0: return {if0.move_accept, if0.move_reject, if0.err_full, if0.err_range, if0.err_turn,
                 if0.err_occupied, if0.locked, 8'(if0.next_player), 16'(if0.move_count),
                 if0.board_full, 256'(if0.marked)};
      1: return {if1.move_accept, if1.move_reject, if1.err_full, if1.err_range, if1.err_turn,
                 if1.err_occupied, if1.locked, 8'(if1.next_player), 16'(if1.move_count),
                 if1.board_full, 256'(if1.marked)};
      2: return {if2.move_accept, if2.move_reject, if2.err_full, if2.err_range, if2.err_turn,
                 if2.err_occupied, if2.locked, 8'(if2.next_player), 16'(if2.move_count),
                 if2.board_full, 256'(if2.marked)};
      default: return '0;
    endcase
  endfunction

  task automatic chk(string name, logic [287:0] act, logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int which, bit ng, bit mv, int p, int c);
    if0.new_game = 1'b0; if0.move_valid = 1'b0; if0.move_player = '0; if0.move_cell = '0;
    if1.new_game = 1'b0; if1.move_valid = 1'b0; if1.move_player = '0; if1.move_cell = '0;
    if2.new_game = 1'b0; if2.move_valid = 1'b0; if2.move_player = '0; if2.move_cell = '0;
    case (which)
      0: begin if0.new_game = ng; if0.move_valid = mv; if0.move_player = 1'(p); if0.move_cell = 4'(c); end
      1: begin if1.new_game = ng; if1.move_valid = mv; if1.move_player = 1'(p); if1.move_cell = 4'(c); end
      2: begin if2.new_game = ng; if2.move_valid = mv; if2.move_player = 2'(p); if2.move_cell = 4'(c); end
      default: ;
    endcase
  endtask

  task automatic cycle(int which, bit ng, bit mv, int p, int c);
    drive(which, ng, mv, p, c);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      mdl[k] = model_step(mdl[k], np_c[k], nc_c[k], lk_c[k],
                          (k == which) ? ng : 1'b0, (k == which) ? mv : 1'b0, p, c);
      chk($sformatf("model_dut%0d", k), act_vec(k), exp_vec(k));
    end
  endtask

  task automatic rst_cycle(bit with_move);
    drive(0, 1'b0, with_move, 0, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mdl[k] = '0;
      chk($sformatf("reset_dut%0d", k), act_vec(k), 288'(0));
    end
  endtask

  task automatic add_vec(int w, bit ng, bit mv, int p, int c,
                         bit acc, bit rej, bit [3:0] err, int nxt, int cnt);
    vec_t v;
    v.which = w; v.ng = ng; v.mv = mv; v.p = p; v.c = c;
    v.acc = acc; v.rej = rej; v.err = err; v.nxt = nxt; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    logic [287:0] a;
    vec_t         v;
    int           which, p, c;
    bit           ng, mv;

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 0, 0);
    rst_cycle(1'b0);

    // three accepted alternating moves (lock-on-error config)
    add_vec(0, 0, 1, 0, 4,  1, 0, 4'b0000, 1, 1);
    add_vec(0, 0, 1, 1, 0,  1, 0, 4'b0000, 0, 2);
    add_vec(0, 0, 1, 0, 8,  1, 0, 4'b0000, 1, 3);
    // keep-playing config: turn error, occupied error, then recovery
    add_vec(1, 0, 1, 0, 0,  1, 0, 4'b0000, 1, 1);
    add_vec(1, 0, 1, 0, 1,  0, 1, 4'b0010, 1, 1);
    add_vec(1, 0, 1, 1, 0,  0, 1, 4'b0001, 1, 1);
    add_vec(1, 0, 1, 1, 2,  1, 0, 4'b0000, 0, 2);
    // three-player, twelve-cell config
    add_vec(2, 0, 1, 0, 0,  1, 0, 4'b0000, 1, 1);
    add_vec(2, 0, 1, 1, 1,  1, 0, 4'b0000, 2, 2);
    add_vec(2, 0, 1, 2, 2,  1, 0, 4'b0000, 0, 3);
    add_vec(2, 0, 1, 0, 3,  1, 0, 4'b0000, 1, 4);
    add_vec(2, 0, 1, 3, 5,  0, 1, 4'b0010, 1, 4);
    add_vec(2, 0, 1, 1, 13, 0, 1, 4'b0100, 1, 4);
    add_vec(2, 0, 1, 1, 5,  1, 0, 4'b0000, 2, 5);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      cycle(v.which, v.ng, v.mv, v.p, v.c);
      a = act_vec(v.which);
      chk($sformatf("vec%0d", i), 288'({a[287:282], a[280:257]}),
          288'({v.acc, v.rej, v.err, 8'(v.nxt), 16'(v.cnt)}));
    end
    a = act_vec(0);
    chk("t1_marked", 288'(a[255:0]), 288'(9'h111));
    a = act_vec(1);
    chk("t2_marked", 288'(a[255:0]), 288'(9'h005));

    // fill the board, then a move in FULL
    cycle(0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1'b0, 1'b1, i % 2, i);
    a = act_vec(0);
    chk("t4_full", 288'({a[256], a[281], a[255:0]}), 288'({1'b1, 1'b0, 256'h1ff}));
    cycle(0, 1'b0, 1'b1, 1, 0);
    a = act_vec(0);
    chk("t4_reject", 288'({a[287:281]}), 288'({1'b0, 1'b1, 4'b1000, 1'b1}));

    // lock on an out-of-turn move; further moves ignored
    cycle(0, 1'b1, 1'b0, 0, 0);
    cycle(0, 1'b0, 1'b1, 1, 0);
    a = act_vec(0);
    chk("t5_lock", 288'({a[287:281]}), 288'({1'b0, 1'b1, 4'b0010, 1'b1}));
    cycle(0, 1'b0, 1'b1, 0, 0);
    cycle(0, 1'b0, 1'b1, 0, 1);
    a = act_vec(0);
    chk("t5_ignored", 288'({a[287:281], a[255:0]}), 288'({1'b0, 1'b0, 4'b0010, 1'b1, 256'h0}));
    cycle(0, 1'b1, 1'b0, 0, 0);
    a = act_vec(0);
    chk("t5_newgame", 288'({a[281:257], a[255:0]}), 288'(0));

    // new_game beats a simultaneous move; reset beats a move mid-game
    cycle(0, 1'b1, 1'b1, 0, 3);
    a = act_vec(0);
    chk("t6_ng_move", 288'({a[287:286], a[255:0]}), 288'(0));
    cycle(0, 1'b0, 1'b1, 0, 3);
    cycle(0, 1'b0, 1'b1, 1, 4);
    rst_cycle(1'b1);

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      which = int'($urandom_range(0, 2));
      ng    = ($urandom_range(0, 15) == 0);
      mv    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) p = int'(mdl[which].nxt);
      else p = int'($urandom_range(0, maxp_c[which]));
      c = int'($urandom_range(0, 15));
      cycle(which, ng, mv, p, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/turn_move_checker.md
Name: turn_move_checker

Overview:
- Clocked, parametrised successor to the single-flag two-player turn checker.
- Sits between the move-input decoder and the board/win logic.
- Checks every move strobe for correct turn order across NUM_PLAYERS, legal cell index and unoccupied cell.
- Keeps the occupancy bitmap, move count, next expected player and per-cause error flags, plus a sticky lock mode.

Parameters:
- NUM_PLAYERS, 2, number of players in rotation (2..16).
- NUM_CELLS, 9, number of board cells (4..256).
- FIRST_PLAYER, 0, player id expected after reset / new_game.
- LOCK_ON_ERROR, 1, 1 = first error freezes block until new_game; 0 = reject bad move and keep playing.
- PW, $clog2(NUM_PLAYERS) (min 1), player id width (derived).
- CW, $clog2(NUM_CELLS), cell index width (derived).
- MW, $clog2(NUM_CELLS+1), move counter width (derived).

Ports:
- clk, in, 1, system clock, rising edge.
- reset, in, 1, synchronous, active-high.
- new_game, in, 1, one-cycle pulse; clears board and errors.
- move_valid, in, 1, one-cycle move strobe.
- move_player, in, PW, id of player making the move.
- move_cell, in, CW, target cell index.
- move_accept, out, 1, one-cycle pulse: move applied.
- move_reject, out, 1, one-cycle pulse: move refused.
- err_turn, out, 1, last rejected move was out of turn or had an invalid player id.
- err_occupied, out, 1, last rejected move targeted a marked cell.
- err_range, out, 1, last rejected move had move_cell >= NUM_CELLS.
- err_full, out, 1, last rejected move arrived with the board full.
- locked, out, 1, block is in LOCKED state.
- next_player, out, PW, id expected on the next move.
- marked, out, NUM_CELLS, occupancy bitmap; bit i set = cell i taken.
- move_count, out, MW, number of accepted moves.
- board_full, out, 1, move_count == NUM_CELLS.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values:
  - marked=0, move_count=0, next_player=FIRST_PLAYER.
  - All err_* = 0; move_accept = move_reject = 0.
  - locked=0, state=PLAY.
- States: PLAY, FULL, LOCKED.
  - PLAY -> FULL on the accepted move that makes move_count == NUM_CELLS.
  - PLAY -> LOCKED on any reject when LOCK_ON_ERROR=1.
  - FULL -> LOCKED on a move attempt when LOCK_ON_ERROR=1.
  - Any state -> PLAY on new_game.
- Evaluation:
  - Move checked in the cycle move_valid=1; outputs registered, so accept/reject and all state updates are visible the next cycle (latency 1).
- Error priority, first match wins; exactly one err_* is set per reject:
  1. Full: state FULL -> err_full.
  2. Range: move_cell >= NUM_CELLS -> err_range.
  3. Turn: move_player >= NUM_PLAYERS or move_player != next_player -> err_turn.
  4. Occupied: marked[move_cell]=1 -> err_occupied.
- Accept:
  - Set marked[move_cell]; move_count+1.
  - next_player advances modulo NUM_PLAYERS (NUM_PLAYERS-1 wraps to 0).
  - All err_* cleared.
- Reject:
  - marked, move_count and next_player unchanged.
  - err_* reflect the cause and hold until the next accept, reject or new_game.
- LOCKED:
  - All move_valid ignored; no accept/reject pulses.
  - err_* hold their values; locked=1.
- new_game:
  - Same effect as reset, minus the reset-only dependency.
  - new_game together with move_valid: new_game wins, the move is dropped with no pulse.
- reset together with anything: reset wins.
- move_valid in two consecutive cycles: each move is evaluated against the state updated by the previous one. Back-to-back moves are supported at full rate.
- With LOCK_ON_ERROR=0, a move in FULL gives a reject with err_full, and the state stays FULL.

Decomposition:
- Package turn_pkg:
  - State enum {PLAY, FULL, LOCKED}.
  - Error-cause encoding.
  - Width-derivation functions (safe clog2 with minimum 1).
- One sub-module, turn_rotator: modulo-NUM_PLAYERS counter with load(FIRST_PLAYER) and advance inputs, output next_player.
- Remaining logic (checks, bitmap, counter, FSM) lives in turn_move_checker.

Test Plan:
1. Defaults, reset, then moves (p0,c4), (p1,c0), (p0,c8) -> three accept pulses; marked=9'b1_0001_0001; move_count=3; next_player=1.
2. Defaults, LOCK_ON_ERROR=0: (p0,c0) then (p0,c1) -> second move rejected with err_turn=1, marked=9'h001, next_player=1. Then (p1,c0) -> rejected with err_occupied=1. Then (p1,c2) -> accepted, errors cleared.
3. NUM_PLAYERS=3, NUM_CELLS=16, LOCK_ON_ERROR=0:
   - Moves p0,p1,p2,p0 -> next_player sequence 1,2,0,1.
   - Move with player id 3 -> err_turn.
   - Move with cell 16 (CW=4 cannot encode 16) is skipped; use NUM_CELLS=12 with cell 13 -> err_range.
4. Defaults: nine legal alternating moves -> board_full=1, state FULL. Tenth move -> reject, err_full=1, then locked=1 (LOCK_ON_ERROR=1).
5. LOCK_ON_ERROR=1: out-of-turn move -> locked=1. Further legal moves -> no pulses, marked unchanged. Then new_game -> locked=0, marked=0, next_player=FIRST_PLAYER.
6. Simultaneous new_game and move_valid (p0,c3) -> no pulse, marked=0. Reset asserted mid-game with move_valid high -> all outputs at reset values next cycle.
